u_proc_mc: RTL and testbench
============================

U_PROC_MC -- requirements
Module: u_proc_mc

Interface
REQ-001 Parameter DATA_W, default 16: datapath, register and memory-data width; values below 16 are not supported.
REQ-002 Parameter ADDR_W, default 16: memory address and PC width.
REQ-003 Parameter NREG, default 16: general register count; values 2..16 are supported.
REQ-004 Parameter PC_INIT, default 1: PC value loaded at reset.
REQ-005 clk_100  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 memory_in  input  DATA_W  read data, sampled when hit=1.
REQ-008 hit  input  1  memory ready; completes the current access.
REQ-009 memory_req  output  1  memory access request.
REQ-010 memory_write_en  output  1  write qualifier, valid while memory_req=1.
REQ-011 address_out  output  ADDR_W  access address; 0 when memory_req=0.
REQ-012 memory_out  output  DATA_W  write data; 0 unless a STORE is in progress.
REQ-013 acc  output  DATA_W  accumulator.
REQ-014 z  output  1  zero flag.
REQ-015 finished  output  1  processor halted.
REQ-016 error  output  1  illegal-opcode trap taken.

Function
REQ-017 Instruction fields: op=[15:12], ra=[11:8], imm8=[7:0]; bits above 15 are ignored, and ra values at or above NREG select R0.
REQ-018 States: FETCH, EXEC, MEM, HALTED.
REQ-019 FETCH: memory_req=1, address_out=PC. On hit: IR<=memory_in, PC<=PC+1 (wraps modulo 2^ADDR_W), next state EXEC. Without hit, all outputs hold.
REQ-020 EXEC, single cycle, next state FETCH:
- 0 NOP.
- 1 LDI: ACC<=zero-extended imm8.
- 2 MOVA: R[ra]<=ACC.
- 3 MOVR: ACC<=R[ra].
- 4 ADD: ACC<=ACC+R[ra].
- 5 SUB: ACC<=ACC-R[ra].
- 6 AND: ACC<=ACC&R[ra].
- 7 XOR: ACC<=ACC^R[ra].
- 8 INC: R[ra]<=R[ra]+1.
- B JMP: PC<=zero-extended imm8.
- C JZ: as JMP if z=1, otherwise NOP.
REQ-021 Arithmetic is modulo 2^DATA_W; carry and overflow are discarded.
REQ-022 z updates only on ADD, SUB, AND, XOR and INC: set when the DATA_W-bit result is 0, cleared otherwise.
REQ-023 EXEC with op 9 (LOAD) or A (STORE) goes to MEM; op F (HALT) goes to HALTED.
REQ-024 MEM: memory_req=1, address_out=low ADDR_W bits of R[ra]; for STORE, memory_write_en=1 and memory_out=ACC. On hit: a LOAD sets ACC<=memory_in; next state FETCH.
REQ-025 Latency with hit held high: 2 cycles per non-memory instruction, 3 per LOAD/STORE.
REQ-026 HALTED: finished=1 and memory_req=0; the state is left only by rst.
REQ-027 R0 reads as 0; writes to R0 are discarded.
REQ-028 Opcodes D and E behave as defined in REQ-036.

Reset
REQ-029 While rst=1: state=FETCH, PC=PC_INIT, ACC=0, IR=0, all registers=0, z=0, finished=0, error=0.
REQ-030 rst asserted during FETCH or MEM abandons the access with no architectural update. In the first cycle after rst deasserts, memory_req=1 and address_out=PC_INIT.
REQ-031 rst has priority over hit in the same cycle.

Configuration
REQ-032 The macro U_PROC_ILLEGAL_TRAP_EN controls illegal-opcode handling.
REQ-033 With U_PROC_ILLEGAL_TRAP_EN defined, opcodes D and E in EXEC set error=1 and go to HALTED (finished=1).
REQ-034 With U_PROC_ILLEGAL_TRAP_EN undefined, opcodes D and E execute as NOP and error is tied to 0.
REQ-035 The port list is identical in both builds.
REQ-036 Opcodes D and E execute per REQ-033 or REQ-034 depending on the build.

Structure
REQ-037 Package u_proc_pkg holds the opcode constants, the state enumeration and the field bit positions.
REQ-038 Sub-module u_proc_regfile holds NREG x DATA_W registers with one synchronous write port, a combinational read port and R0 hardwired to zero.

Verification
REQ-039 Reset, then hit=1 with program LDI 5; MOVA R1; ADD R1; HALT -> acc=10, z=0, finished=1 on cycle 8.
REQ-040 LDI 3; MOVA R2; SUB R2; JZ 0x20 -> z=1, next fetch address_out=0x0020.
REQ-041 STORE with R1=0x0040, ACC=0x1234 and hit held low for 3 cycles -> memory_req, memory_write_en, address_out=0x0040 and memory_out=0x1234 stable for 4 cycles; FETCH follows.
REQ-042 PC=0xFFFF fetches a NOP -> next address_out=0x0000.
REQ-043 rst pulsed during MEM of a LOAD while memory_in=0xBEEF -> acc stays 0 and the next access is address_out=PC_INIT.
REQ-044 Opcode E executed -> error=1 and finished=1 with U_PROC_ILLEGAL_TRAP_EN defined; without it, the instruction completes as NOP in 2 cycles.

Source files
------------

// File: rtl/u_proc_pkg.sv
// rtl/u_proc_pkg.sv - opcode constants, FSM states and instruction field positions for u_proc_mc
package u_proc_pkg;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RA_HI  = 11;
  localparam int RA_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  localparam int RA_W   = RA_HI - RA_LO + 1;
  localparam int INSN_W = OP_HI + 1;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LDI   = 4'h1,
    OP_MOVA  = 4'h2,
    OP_MOVR  = 4'h3,
    OP_ADD   = 4'h4,
    OP_SUB   = 4'h5,
    OP_AND   = 4'h6,
    OP_XOR   = 4'h7,
    OP_INC   = 4'h8,
    OP_LOAD  = 4'h9,
    OP_STORE = 4'hA,
    OP_JMP   = 4'hB,
    OP_JZ    = 4'hC,
    OP_ILL_D = 4'hD,
    OP_ILL_E = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    MEM    = 2'd2,
    HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/u_proc_regfile.sv
// rtl/u_proc_regfile.sv - NREG x DATA_W register file, one sync write port, one comb read port, R0 reads zero
module u_proc_regfile
  import u_proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr,
  output logic [DATA_W-1:0] rdata
);

  // No storage for R0; indices at or above NREG never match, so they alias R0.
  logic [DATA_W-1:0] regs [1:NREG-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      for (int i = 1; i < NREG; i++) begin
        if (waddr == RA_W'(i)) regs[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 1; i < NREG; i++) begin
      if (raddr == RA_W'(i)) rdata = regs[i];
    end
  end

endmodule

// File: rtl/u_proc_mc.sv
// rtl/u_proc_mc.sv - multi-cycle accumulator processor; U_PROC_ILLEGAL_TRAP_EN traps opcodes D/E
module u_proc_mc
  import u_proc_pkg::*;
#(
  parameter int          DATA_W  = 16,
  parameter int          ADDR_W  = 16,
  parameter int          NREG    = 16,
  parameter int unsigned PC_INIT = 1
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic [DATA_W-1:0] memory_in,
  input  logic              hit,
  output logic              memory_req,
  output logic              memory_write_en,
  output logic [ADDR_W-1:0] address_out,
  output logic [DATA_W-1:0] memory_out,
  output logic [DATA_W-1:0] acc,
  output logic              z,
  output logic              finished,
  output logic              error
);

  state_e              state, state_d;
  logic [ADDR_W-1:0]   pc, pc_d;
  logic [INSN_W-1:0]   ir, ir_d;
  logic [DATA_W-1:0]   acc_d;
  logic                z_d;
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata, rf_rdata;
  opcode_e             op;
  logic [RA_W-1:0]     ra;
  logic [7:0]          imm8;
`ifdef U_PROC_ILLEGAL_TRAP_EN
  logic                trap;
`endif

  assign op   = opcode_e'(ir[OP_HI:OP_LO]);
  assign ra   = ir[RA_HI:RA_LO];
  assign imm8 = ir[IMM_HI:IMM_LO];

  u_proc_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk   (clk_100),
    .rst   (rst),
    .we    (rf_we),
    .waddr (ra),
    .wdata (rf_wdata),
    .raddr (ra),
    .rdata (rf_rdata)
  );

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state <= FETCH;
      pc    <= ADDR_W'(PC_INIT);
      ir    <= '0;
      acc   <= '0;
      z     <= 1'b0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      ir    <= ir_d;
      acc   <= acc_d;
      z     <= z_d;
    end
  end

  always_comb begin
    state_d         = state;
    pc_d            = pc;
    ir_d            = ir;
    acc_d           = acc;
    z_d             = z;
    rf_we           = 1'b0;
    rf_wdata        = acc;
    memory_req      = 1'b0;
    memory_write_en = 1'b0;
    address_out     = '0;
    memory_out      = '0;
`ifdef U_PROC_ILLEGAL_TRAP_EN
    trap            = 1'b0;
`endif
    case (state)
      FETCH: begin
        memory_req  = 1'b1;
        address_out = pc;
        if (hit) begin
          ir_d    = memory_in[INSN_W-1:0];
          pc_d    = pc + ADDR_W'(1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
        case (op)
          OP_LDI:  acc_d = DATA_W'(imm8);
          OP_MOVA: rf_we = 1'b1;
          OP_MOVR: acc_d = rf_rdata;
          OP_ADD:  begin acc_d = acc + rf_rdata; z_d = ~|acc_d; end
          OP_SUB:  begin acc_d = acc - rf_rdata; z_d = ~|acc_d; end
          OP_AND:  begin acc_d = acc & rf_rdata; z_d = ~|acc_d; end
          OP_XOR:  begin acc_d = acc ^ rf_rdata; z_d = ~|acc_d; end
          OP_INC: begin
            rf_we    = 1'b1;
            rf_wdata = rf_rdata + DATA_W'(1);
            z_d      = ~|rf_wdata;
          end
          OP_JMP:  pc_d = ADDR_W'(imm8);
          OP_JZ:   if (z) pc_d = ADDR_W'(imm8);
          OP_LOAD, OP_STORE: state_d = MEM;
          OP_HALT: state_d = HALTED;
`ifdef U_PROC_ILLEGAL_TRAP_EN
          OP_ILL_D, OP_ILL_E: begin
            trap    = 1'b1;
            state_d = HALTED;
          end
`endif
          default: ;
        endcase
      end
      MEM: begin
        // The address register is the same R[ra] that INC/MOVA would target.
        memory_req  = 1'b1;
        address_out = ADDR_W'(rf_rdata);
        if (op == OP_STORE) begin
          memory_write_en = 1'b1;
          memory_out      = acc;
        end
        if (hit) begin
          if (op == OP_LOAD) acc_d = memory_in;
          state_d = FETCH;
        end
      end
      default: ;
    endcase
  end

  assign finished = (state == HALTED);

`ifdef U_PROC_ILLEGAL_TRAP_EN
  always_ff @(posedge clk_100) begin
    if (rst)       error <= 1'b0;
    else if (trap) error <= 1'b1;
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_u_proc_mc.sv
// tb/tb_u_proc_mc.sv - scoreboard bench for u_proc_mc; follows U_PROC_ILLEGAL_TRAP_EN when defined
module tb_u_proc_mc;

  logic        clk_100 = 1'b0;
  logic        rst = 1'b1;
  logic        hit = 1'b0;
  logic [15:0] memory_in;
  logic        memory_req, memory_write_en, z, finished, error;
  logic [15:0] address_out, memory_out, acc;

  logic [15:0] zero_word = 16'h0000;
  logic        w_req, w_we, w_z, w_fin, w_err;
  logic [15:0] w_addr, w_mout, w_acc;

  logic [15:0] mem [0:65535];
  assign memory_in = mem[address_out];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } access_t;
  access_t exp_q[$];
  logic    sb_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_100 = ~clk_100;

  u_proc_mc dut (
    .clk_100         (clk_100),
    .rst             (rst),
    .memory_in       (memory_in),
    .hit             (hit),
    .memory_req      (memory_req),
    .memory_write_en (memory_write_en),
    .address_out     (address_out),
    .memory_out      (memory_out),
    .acc             (acc),
    .z               (z),
    .finished        (finished),
    .error           (error)
  );

  u_proc_mc #(.PC_INIT(16'hFFFF)) dut_wrap (
    .clk_100         (clk_100),
    .rst             (rst),
    .memory_in       (zero_word),
    .hit             (hit),
    .memory_req      (w_req),
    .memory_write_en (w_we),
    .address_out     (w_addr),
    .memory_out      (w_mout),
    .acc             (w_acc),
    .z               (w_z),
    .finished        (w_fin),
    .error           (w_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
  endtask

  task automatic push_fetch(input logic [15:0] a);
    exp_q.push_back('{1'b0, a, 16'h0000});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hit = 1'b0;
    tick();
    tick();
    check_eq("rst_acc", acc, 0);
    check_eq("rst_z", z, 0);
    check_eq("rst_finished", finished, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_req", memory_req, 1);
    check_eq("rst_addr", address_out, 16'h0001);
    check_eq("rst_we", memory_write_en, 0);
    check_eq("rst_mout", memory_out, 0);
    rst = 1'b0;
  endtask

  task automatic run_until_finished(input int bound);
    int n = 0;
    while (!finished && n < bound) begin
      tick();
      n++;
    end
    check_eq("halt_timeout", finished, 1);
  endtask

  task automatic sb_drain(input string tag);
    check_eq(tag, exp_q.size(), 0);
    exp_q.delete();
    sb_en = 1'b0;
  endtask

  // Every completed access is compared against the next expected one.
  always @(negedge clk_100) begin
    access_t e;
    if (!rst && memory_req && hit) begin
      if (memory_write_en) mem[address_out] <= memory_out;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_extra_access", {16'h0, address_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_addr", address_out, e.addr);
          check_eq("sb_we", memory_write_en, e.we);
          if (e.we) check_eq("sb_wdata", memory_out, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // LDI 5; MOVA R1; ADD R1; HALT
    clear_mem();
    mem[1] = 16'h1005; mem[2] = 16'h2100; mem[3] = 16'h4100; mem[4] = 16'hF000;
    sb_en = 1'b1;
    for (int a = 1; a <= 4; a++) push_fetch(16'(a));
    do_reset();
    hit = 1'b1;
    repeat (7) tick();
    check_eq("t1_not_halted_c7", finished, 0);
    tick();
    check_eq("t1_finished_c8", finished, 1);
    check_eq("t1_acc", acc, 16'd10);
    check_eq("t1_z", z, 0);
    check_eq("t1_req_halted", memory_req, 0);
    check_eq("t1_addr_idle", address_out, 0);
    check_eq("t1_error", error, 0);
    sb_drain("t1_sb_drain");
    hit = 1'b0;

    // LDI 3; MOVA R2; SUB R2; JZ 0x20
    clear_mem();
    mem[1] = 16'h1003; mem[2] = 16'h2200; mem[3] = 16'h5200; mem[4] = 16'hC020;
    sb_en = 1'b1;
    for (int a = 1; a <= 4; a++) push_fetch(16'(a));
    do_reset();
    hit = 1'b1;
    repeat (8) tick();
    hit = 1'b0;
    check_eq("t2_z", z, 1);
    check_eq("t2_acc", acc, 0);
    check_eq("t2_req", memory_req, 1);
    check_eq("t2_jz_target", address_out, 16'h0020);
    sb_drain("t2_sb_drain");

    // AND / XOR / INC / MOVR, R0 discard and z retention
    clear_mem();
    mem[1] = 16'h10F0; mem[2] = 16'h2400; mem[3] = 16'h103C; mem[4] = 16'h6400;
    mem[5] = 16'h7400; mem[6] = 16'h2500; mem[7] = 16'h8500; mem[8] = 16'h3500;
    mem[9] = 16'h2000; mem[10] = 16'h3000; mem[11] = 16'hF000;
    do_reset();
    hit = 1'b1;
    repeat (8) tick();
    check_eq("t3_and", acc, 16'h0030);
    check_eq("t3_and_z", z, 0);
    repeat (2) tick();
    check_eq("t3_xor", acc, 16'h00C0);
    repeat (6) tick();
    check_eq("t3_inc_movr", acc, 16'h00C1);
    check_eq("t3_inc_z", z, 0);
    run_until_finished(40);
    check_eq("t3_r0_zero", acc, 16'h0000);
    check_eq("t3_z_held", z, 0);
    hit = 1'b0;

    // STORE of 0x1234 to R1=0x0040 with a 3-cycle memory stall
    clear_mem();
    mem[1] = 16'h1040; mem[2] = 16'h2100; mem[3] = 16'h1012;
    for (int k = 0; k < 8; k++) begin
      mem[4 + 2 * k] = 16'h2300;
      mem[5 + 2 * k] = 16'h4300;
    end
    mem[20] = 16'h2300; mem[21] = 16'h1034; mem[22] = 16'h4300;
    mem[23] = 16'hA100; mem[24] = 16'hF000;
    sb_en = 1'b1;
    for (int a = 1; a <= 23; a++) push_fetch(16'(a));
    exp_q.push_back('{1'b1, 16'h0040, 16'h1234});
    push_fetch(16'd24);
    do_reset();
    hit = 1'b1;
    repeat (45) tick();
    hit = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t4_req_c%0d", k), memory_req, 1);
      check_eq($sformatf("t4_we_c%0d", k), memory_write_en, 1);
      check_eq($sformatf("t4_addr_c%0d", k), address_out, 16'h0040);
      check_eq($sformatf("t4_wdata_c%0d", k), memory_out, 16'h1234);
      if (k == 3) hit = 1'b1;
      tick();
    end
    check_eq("t4_fetch_addr", address_out, 16'd24);
    check_eq("t4_fetch_we", memory_write_en, 0);
    check_eq("t4_fetch_mout", memory_out, 0);
    tick();
    tick();
    check_eq("t4_finished", finished, 1);
    check_eq("t4_mem_written", mem[16'h0040], 16'h1234);
    sb_drain("t4_sb_drain");
    hit = 1'b0;

    // PC wrap at 0xFFFF (second instance starts there)
    clear_mem();
    do_reset();
    check_eq("t5_wrap_start", w_addr, 16'hFFFF);
    check_eq("t5_wrap_req", w_req, 1);
    hit = 1'b1;
    tick();
    tick();
    hit = 1'b0;
    check_eq("t5_wrap_next", w_addr, 16'h0000);
    check_eq("t5_wrap_req2", w_req, 1);
    check_eq("t5_wrap_we", w_we, 0);
    check_eq("t5_wrap_mout", w_mout, 0);
    check_eq("t5_wrap_acc", w_acc, 0);
    check_eq("t5_wrap_z", w_z, 0);
    check_eq("t5_wrap_fin", w_fin, 0);
    check_eq("t5_wrap_err", w_err, 0);

    // rst during MEM of LOAD R0 with 0xBEEF on the bus
    clear_mem();
    mem[0] = 16'hBEEF; mem[1] = 16'h9000;
    do_reset();
    hit = 1'b1;
    tick();
    hit = 1'b0;
    tick();
    check_eq("t6_mem_req", memory_req, 1);
    check_eq("t6_mem_addr", address_out, 16'h0000);
    check_eq("t6_mem_we", memory_write_en, 0);
    rst = 1'b1;
    hit = 1'b1;
    tick();
    rst = 1'b0;
    hit = 1'b0;
    check_eq("t6_acc_after_rst", acc, 0);
    check_eq("t6_req_after_rst", memory_req, 1);
    check_eq("t6_addr_after_rst", address_out, 16'h0001);
    tick();
    check_eq("t6_acc_hold", acc, 0);
    check_eq("t6_addr_hold", address_out, 16'h0001);

    // Opcode E
    clear_mem();
    mem[1] = 16'hE000; mem[2] = 16'h1007; mem[3] = 16'hF000;
    do_reset();
    hit = 1'b1;
    tick();
    tick();
`ifdef U_PROC_ILLEGAL_TRAP_EN
    check_eq("t7_error", error, 1);
    check_eq("t7_finished", finished, 1);
    check_eq("t7_req", memory_req, 0);
    tick();
    check_eq("t7_error_sticky", error, 1);
    check_eq("t7_acc", acc, 0);
`else
    check_eq("t7_error", error, 0);
    check_eq("t7_finished", finished, 0);
    check_eq("t7_next_fetch", address_out, 16'h0002);
    check_eq("t7_req", memory_req, 1);
    run_until_finished(20);
    check_eq("t7_acc", acc, 16'h0007);
    check_eq("t7_error_end", error, 0);
`endif
    hit = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
